// File: rtl/subleq_seq.sv
// SUBLEQ instruction sequencer driving an external 2R/1W register file (3 clocks per instruction).
// Optional single-step pause state is enabled by defining SUBLEQ_STEP_EN.
module subleq_seq #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int HALT_ADDR = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              step,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [ADDR_W-1:0] host_raddr,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       icount,
  output logic [DATA_W-1:0] rf_w_data,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic              rf_w_ena,
  output logic [ADDR_W-1:0] rf_ra_addr,
  output logic [ADDR_W-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data
);

`ifdef SUBLEQ_STEP_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_PAUSE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC} state_t;
`endif

  localparam int INSTR_W = 3 * ADDR_W;

  state_t              state;
  logic [INSTR_W-1:0]  instr;
  logic [ADDR_W-1:0]   instr_a, instr_b, instr_c;
  logic [ADDR_W-1:0]   fetch_a, fetch_b;
  logic [DATA_W-1:0]   diff;
  logic                leq;
  logic [ADDR_W-1:0]   next_pc;
  logic                unused_ok;

  assign instr_a = instr[3*ADDR_W-1 -: ADDR_W];
  assign instr_b = instr[2*ADDR_W-1 -: ADDR_W];
  assign instr_c = instr[ADDR_W-1:0];
  // Operand addresses come straight off the read port in DECODE, before instr is latched.
  assign fetch_a = rf_ra_data[3*ADDR_W-1 -: ADDR_W];
  assign fetch_b = rf_ra_data[2*ADDR_W-1 -: ADDR_W];

  assign diff    = rf_rb_data - rf_ra_data;
  assign leq     = diff[DATA_W-1] | (diff == '0);
  assign next_pc = leq ? instr_c : pc + ADDR_W'(1);

  assign busy       = (state != S_IDLE);
  assign host_rdata = rf_rb_data;
  assign unused_ok  = &{1'b0, step, rf_ra_data[DATA_W-1:INSTR_W]};

  always_comb begin
    rf_w_ena   = 1'b0;
    rf_w_addr  = host_waddr;
    rf_w_data  = host_wdata;
    rf_ra_addr = pc;
    rf_rb_addr = host_raddr;
    case (state)
      S_IDLE:   rf_w_ena = host_we;
      S_DECODE: begin
        rf_ra_addr = fetch_a;
        rf_rb_addr = fetch_b;
      end
      S_EXEC: begin
        rf_ra_addr = instr_a;
        rf_rb_addr = instr_b;
        rf_w_ena   = 1'b1;
        rf_w_addr  = instr_b;
        rf_w_data  = diff;
      end
      default: ;
    endcase
    // An instruction interrupted by reset must never commit its write.
    if (rst) rf_w_ena = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      halted <= 1'b0;
      icount <= '0;
      instr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc     <= start_pc;
            halted <= 1'b0;
            icount <= '0;
            state  <= S_FETCH;
          end
        end
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          instr <= rf_ra_data[INSTR_W-1:0];
          state <= S_EXEC;
        end
        S_EXEC: begin
          pc     <= next_pc;
          icount <= icount + 16'd1;
          if (next_pc == ADDR_W'(HALT_ADDR)) begin
            halted <= 1'b1;
            state  <= S_IDLE;
          end else begin
`ifdef SUBLEQ_STEP_EN
            state <= S_PAUSE;
`else
            state <= S_FETCH;
`endif
          end
        end
`ifdef SUBLEQ_STEP_EN
        S_PAUSE: if (step) state <= S_FETCH;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
